// File: rtl/ifu_prefetch.sv
// Prefetching instruction-fetch unit: in-order fetch requests, a PC tag queue for
// outstanding requests, and a DEPTH-entry instruction FIFO that feeds decode.
module ifu_prefetch #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000,
  parameter int              DEPTH    = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            halt,
  output logic            req_valid,
  input  logic            req_ready,
  output logic [XLEN-1:0] req_addr,
  input  logic            rsp_valid,
  input  logic [XLEN-1:0] rsp_data,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] inst,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] snpc
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0] DEPTH_W = DEPTH[CW:0];

  typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

  state_t          state;
  logic [XLEN-1:0] fetch_pc;
  logic [CW-1:0]   count, inflight, drop, inflight_nxt;
  logic [PW-1:0]   rd_ptr, wr_ptr, tag_rd, tag_wr;
  logic [CW:0]     occupancy;
  logic            issue, retire, discard, push, pop;

  logic [XLEN-1:0] fifo_inst [DEPTH];
  logic [XLEN-1:0] fifo_pc   [DEPTH];
  logic [XLEN-1:0] tag_pc    [DEPTH];

  // Credit counts both buffered words and requests still owed a response.
  assign occupancy = {1'b0, count} + {1'b0, inflight};
  assign req_valid = (state == RUN) && !redirect && (occupancy < DEPTH_W);
  assign req_addr  = fetch_pc;

  assign issue        = req_valid && req_ready;
  assign retire       = rsp_valid && (inflight != '0);
  assign discard      = retire && (drop != '0);
  assign push         = retire && !discard && !redirect;
  assign pop          = inst_valid && inst_ready && !redirect;
  assign inflight_nxt = inflight + CW'(issue) - CW'(retire);

  assign inst_valid = (count != '0);
  assign inst       = fifo_inst[rd_ptr];
  assign pc         = fifo_pc[rd_ptr];
  assign snpc       = pc + XLEN'(4);

  // NOTE: state registers use non-blocking assignment so every block sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= BOOT;
    end else begin
      case (state)
        BOOT:    state <= RUN;
        RUN:     if (halt) state <= HALT;
        HALT:    if (!halt || redirect) state <= RUN;
        default: state <= BOOT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      count    <= '0;
      inflight <= '0;
      drop     <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      tag_rd   <= '0;
      tag_wr   <= '0;
    end else begin
      inflight <= inflight_nxt;
      if (issue)  tag_wr <= tag_wr + 1'b1;
      if (retire) tag_rd <= tag_rd + 1'b1;
      if (redirect) begin
        // Everything still owed a response now belongs to the abandoned path.
        fetch_pc <= redirect_pc & ~XLEN'(3);
        count    <= '0;
        rd_ptr   <= wr_ptr;
        drop     <= inflight_nxt;
      end else begin
        if (issue)   fetch_pc <= fetch_pc + XLEN'(4);
        if (push)    wr_ptr   <= wr_ptr + 1'b1;
        if (pop)     rd_ptr   <= rd_ptr + 1'b1;
        if (discard) drop     <= drop - 1'b1;
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end

  // NOTE: FIFO storage is reset so the head outputs read inst=0, pc=RESET_PC after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        fifo_inst[i] <= '0;
        fifo_pc[i]   <= RESET_PC;
      end
    end else if (push) begin
      fifo_inst[wr_ptr] <= rsp_data;
      fifo_pc[wr_ptr]   <= tag_pc[tag_rd];
    end
  end

  // Tag entries are only read while their request is outstanding, so no reset is needed.
  always_ff @(posedge clk) begin
    if (issue) tag_pc[tag_wr] <= fetch_pc;
  end

endmodule

// File: tb/tb_ifu_prefetch.sv
// Scoreboarded bench for ifu_prefetch: a fixed-latency memory model, a monitor that
// checks requests and deliveries against expected queues, and directed scenario checks.
module tb_ifu_prefetch;

  localparam logic [31:0] RESET_PC = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst, redirect, halt, req_valid, req_ready, rsp_valid, inst_valid, inst_ready;
  logic [31:0] redirect_pc, req_addr, rsp_data, inst, pc, snpc;

  typedef struct {logic [31:0] pc; logic [31:0] word;} exp_t;
  typedef struct {logic [31:0] addr; int due;} mreq_t;

  exp_t        exp_q[$];
  mreq_t       mq[$];
  logic [31:0] got_pc[$];
  logic [31:0] model_pc;
  int          n_cmp = 0, n_fail = 0;
  int          cyc = 0, mem_lat = 1;
  int          n_req = 0, n_deliv = 0;

  ifu_prefetch dut (
    .clk(clk), .rst(rst), .redirect(redirect), .redirect_pc(redirect_pc), .halt(halt),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .pc(pc), .snpc(snpc)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return a ^ 32'h5A5A_A5A5;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_models();
    exp_q.delete();
    got_pc.delete();
    n_req   = 0;
    n_deliv = 0;
  endtask

  task automatic do_reset();
    tick(1);
    rst = 1'b1; redirect = 1'b0; halt = 1'b0; req_ready = 1'b0; inst_ready = 1'b0;
    mq.delete();
    clear_models();
    model_pc = RESET_PC;
    tick(2);
    rst = 1'b0;
  endtask

  task automatic start_redirect(input logic [31:0] tgt);
    redirect    = 1'b1;
    redirect_pc = tgt;
    clear_models();
    model_pc    = tgt & ~32'h3;
  endtask

  task automatic wait_deliv(input string name, input int n, input int budget);
    int k = 0;
    while (n_deliv < n && k < budget) begin
      tick(1);
      k++;
    end
    check(name, 32'(n_deliv >= n), 32'd1);
  endtask

  // Memory: responds in order, mem_lat cycles after acceptance, one word per cycle.
  initial begin : memory
    mreq_t m;
    rsp_valid = 1'b0;
    rsp_data  = '0;
    forever begin
      @(negedge clk);
      if (!rst && req_valid && req_ready) begin
        m.addr = req_addr;
        m.due  = cyc + mem_lat;
        mq.push_back(m);
      end
      @(posedge clk);
      cyc++;
      #1;
      if (mq.size() > 0 && mq[0].due <= cyc) begin
        rsp_valid = 1'b1;
        rsp_data  = memf(mq[0].addr);
        void'(mq.pop_front());
      end else begin
        rsp_valid = 1'b0;
        rsp_data  = '0;
      end
    end
  end

  // Monitor: every accepted request must follow the expected PC stream and queues its
  // expected instruction; every delivery is compared against the queue head.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (req_valid && req_ready) begin
          check("req_addr", req_addr, model_pc);
          e.pc   = model_pc;
          e.word = memf(model_pc);
          exp_q.push_back(e);
          model_pc = model_pc + 32'd4;
          n_req++;
        end
        if (inst_valid && inst_ready && !redirect) begin
          n_deliv++;
          got_pc.push_back(pc);
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_inst: got pc %h, expected no delivery", pc);
          end else begin
            e = exp_q.pop_front();
            check("inst_pc", pc, e.pc);
            check("inst_word", inst, e.word);
            check("inst_snpc", snpc, e.pc + 32'd4);
          end
        end
      end
    end
  end

  initial begin : timeout
    #200000;
    $display("FAIL global_timeout: got no finish, expected finish before 200000");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    int n0, k;
    rst = 1'b1; redirect = 1'b0; redirect_pc = '0; halt = 1'b0;
    req_ready = 1'b0; inst_ready = 1'b0; model_pc = RESET_PC;

    // 1: reset values, then a 1-cycle memory with decode always ready.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_req_valid", 32'(req_valid), 32'd0);
    check("rst_req_addr", req_addr, 32'h8000_0000);
    check("rst_inst_valid", 32'(inst_valid), 32'd0);
    check("rst_inst", inst, 32'h0);
    check("rst_pc", pc, 32'h8000_0000);
    check("rst_snpc", snpc, 32'h8000_0004);
    @(posedge clk);
    #1;
    rst = 1'b0; req_ready = 1'b1; inst_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      check($sformatf("t1_inst_valid_c%0d", i), 32'(inst_valid), 32'(i == 4));
      if (i == 1) check("t1_boot_req_valid", 32'(req_valid), 32'd0);
      if (i == 2) check("t1_first_req", req_addr, 32'h8000_0000);
      if (i == 3) check("t1_second_req", req_addr, 32'h8000_0004);
      if (i == 4) check("t1_first_pc", pc, 32'h8000_0000);
    end
    tick(1);
    wait_deliv("t1_deliv", 8, 50);
    check("t1_third_pc", got_pc[2], 32'h8000_0008);

    // 2: decode stalled, FIFO fills to DEPTH and issue stops; release drains in order.
    do_reset();
    req_ready = 1'b1;
    tick(12);
    @(negedge clk);
    check("t2_req_count", 32'(n_req), 32'd4);
    check("t2_req_valid_full", 32'(req_valid), 32'd0);
    check("t2_inst_valid_full", 32'(inst_valid), 32'd1);
    tick(1);
    inst_ready = 1'b1;
    wait_deliv("t2_deliv", 4, 20);
    for (int i = 0; i < 4; i++)
      check($sformatf("t2_pc%0d", i), got_pc[i], 32'h8000_0000 + 32'(4 * i));
    tick(4);
    check("t2_issue_resumed", 32'(n_req > 4), 32'd1);

    // 3: redirect with two requests outstanding on a 3-cycle memory.
    do_reset();
    mem_lat = 3; req_ready = 1'b1; inst_ready = 1'b1;
    k = 0;
    while (n_req < 2 && k < 20) begin
      tick(1);
      k++;
    end
    check("t3_two_inflight", 32'(n_req), 32'd2);
    req_ready = 1'b0;
    start_redirect(32'h8000_0102);
    @(negedge clk);
    check("t3_redirect_req_valid", 32'(req_valid), 32'd0);
    tick(1);
    redirect = 1'b0; req_ready = 1'b1;
    @(negedge clk);
    check("t3_new_req_valid", 32'(req_valid), 32'd1);
    check("t3_new_req_addr", req_addr, 32'h8000_0100);
    check("t3_inst_valid_flushed", 32'(inst_valid), 32'd0);
    tick(1);
    wait_deliv("t3_deliv", 3, 40);
    check("t3_first_pc", got_pc[0], 32'h8000_0100);

    // 4: redirect in a cycle that also has a response, a push and a pop.
    do_reset();
    mem_lat = 2; req_ready = 1'b1; inst_ready = 1'b1;
    tick(10);
    start_redirect(32'h8000_0200);
    @(negedge clk);
    check("t4_rsp_same_cycle", 32'(rsp_valid), 32'd1);
    check("t4_pop_same_cycle", 32'(inst_valid), 32'd1);
    tick(1);
    redirect = 1'b0;
    @(negedge clk);
    check("t4_empty_after", 32'(inst_valid), 32'd0);
    check("t4_new_req_addr", req_addr, 32'h8000_0200);
    tick(1);
    wait_deliv("t4_deliv", 6, 40);
    check("t4_first_pc", got_pc[0], 32'h8000_0200);

    // 5: halt stops issue while outstanding responses drain; release resumes sequentially.
    do_reset();
    mem_lat = 3; req_ready = 1'b1; inst_ready = 1'b1;
    tick(10);
    halt = 1'b1;
    tick(2);
    n0 = n_req;
    tick(8);
    @(negedge clk);
    check("t5_no_new_reqs", 32'(n_req), 32'(n0));
    check("t5_req_valid_halted", 32'(req_valid), 32'd0);
    check("t5_drained_all", 32'(n_deliv), 32'(n0));
    check("t5_fifo_empty", 32'(inst_valid), 32'd0);
    tick(1);
    halt = 1'b0;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!req_valid && k < 10);
    check("t5_resume_valid", 32'(req_valid), 32'd1);
    check("t5_resume_addr", req_addr, RESET_PC + 32'(4 * n0));

    // 6: redirect to the top of the address space, fill the FIFO, then reset while full.
    do_reset();
    mem_lat = 1; req_ready = 1'b1;
    tick(1);
    start_redirect(32'hFFFF_FFFC);
    tick(1);
    redirect = 1'b0;
    @(negedge clk);
    check("t6_req_top", req_addr, 32'hFFFF_FFFC);
    tick(1);
    @(negedge clk);
    check("t6_req_wrap", req_addr, 32'h0000_0000);
    tick(8);
    @(negedge clk);
    check("t6_full_inst_valid", 32'(inst_valid), 32'd1);
    check("t6_full_req_valid", 32'(req_valid), 32'd0);
    check("t6_head_pc", pc, 32'hFFFF_FFFC);
    check("t6_head_snpc", snpc, 32'h0000_0000);
    check("t6_head_inst", inst, 32'hA5A5_5A59);
    tick(1);
    rst = 1'b1;
    mq.delete();
    clear_models();
    model_pc = RESET_PC;
    tick(1);
    @(negedge clk);
    check("t6_rst_inst_valid", 32'(inst_valid), 32'd0);
    check("t6_rst_req_addr", req_addr, 32'h8000_0000);
    check("t6_rst_pc", pc, 32'h8000_0000);
    tick(1);
    rst = 1'b0; inst_ready = 1'b1;
    wait_deliv("t6_deliv", 2, 20);
    check("t6_post_rst_pc", got_pc[0], 32'h8000_0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
